// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: splits LB/LH/LW(U)/SB/SH/SW into little-endian single-byte
// memory cycles on an 8-bit data memory and returns a one-cycle response pulse.
module lsu_byte_sequencer #(
    parameter int MEM_BYTES   = 1024,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_illegal, req_misalign, req_range, req_err;
    logic [1:0]  req_last_k, last_k;
    logic [32:0] req_last_addr;

    // Byte count minus one from funct3: B/BU -> 0, H/HU -> 1, W -> 3.
    assign req_last_k = req_funct3[1] ? 2'd3 : (req_funct3[0] ? 2'd1 : 2'd0);
    assign last_k     = f3_q[1] ? 2'd3 : (f3_q[0] ? 2'd1 : 2'd0);

    always_comb begin
        req_illegal   = req_write ? (req_funct3 > 3'd2)
                                  : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
        req_misalign  = CHECK_ALIGN &&
                        ((req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                         (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0));
        // 33-bit sum so a wrap past 2^32 is caught as out of range.
        req_last_addr = {1'b0, req_addr} + {31'b0, req_last_k};
        req_range     = req_last_addr[32] || (req_last_addr[31:0] >= 32'(MEM_BYTES));
        req_err       = req_illegal || req_misalign || req_range;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    k_d     = '0;
                    err_d   = req_err;
                    state_d = req_err ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!write_q)
                    rdata_d[{k_q, 3'b000} +: 8] = mem_read_data[7:0];
                if (k_q == last_k)
                    state_d = DONE;
                else
                    k_d = k_q + 2'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_err       = 1'b0;
        mem_MemWrite   = 1'b0;
        mem_MemRead    = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            ACCESS: begin
                mem_address    = addr_q + {30'b0, k_q};
                mem_MemWrite   = write_q;
                mem_MemRead    = ~write_q;
                mem_write_data = write_q ? {24'b0, wdata_q[{k_q, 3'b000} +: 8]} : '0;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !write_q) begin
                    case (f3_q)
                        3'd0:    resp_rdata = {{24{rdata_q[7]}}, rdata_q[7:0]};
                        3'd1:    resp_rdata = {{16{rdata_q[15]}}, rdata_q[15:0]};
                        3'd4:    resp_rdata = {24'b0, rdata_q[7:0]};
                        3'd5:    resp_rdata = {16'b0, rdata_q[15:0]};
                        default: resp_rdata = rdata_q;
                    endcase
                end
            end
            default: ;
        endcase
        busy = ~req_ready;
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: byte memory, array-based reference model of the
// load/store rules, directed cases plus randomized transactions.
module tb_lsu_byte_sequencer;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        mem_MemWrite, mem_MemRead;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [7:0]  dmem   [0:MB-1];
    logic [7:0]  refmem [0:MB-1];
    logic        init_mem;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.MEM_BYTES(MB), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    function automatic logic [7:0] pat(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MB; i++) dmem[i] <= pat(i);
        end else if (mem_MemWrite && mem_address < MB) begin
            dmem[mem_address[9:0]] <= mem_write_data[7:0];
        end
    end

    assign mem_read_data = (mem_address < MB) ? {24'b0, dmem[mem_address[9:0]]} : 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules, in plain arithmetic.
    function automatic int m_n(int f3);
        if (f3 == 2) return 4;
        if (f3 == 1 || f3 == 5) return 2;
        return 1;
    endfunction

    function automatic bit m_err(bit w, int f3, logic [31:0] a);
        longint last;
        bit illegal, mis;
        illegal = w ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        mis     = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
        last    = longint'(a) + m_n(f3) - 1;
        return illegal || mis || (last >= MB);
    endfunction

    function automatic logic [31:0] m_load(int f3, logic [31:0] a);
        longint v = 0;
        for (int i = 0; i < m_n(f3); i++) v += longint'(refmem[int'(a) + i]) << (8 * i);
        if (f3 == 0 && v >= 128)   v = v - 256 + 64'h1_0000_0000;
        if (f3 == 1 && v >= 32768) v = v - 65536 + 64'h1_0000_0000;
        return 32'(v);
    endfunction

    // Issue one request from a negedge in IDLE and follow it to its response.
    task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        bit          e;
        int          n, got;
        logic [31:0] exp_rd;
        logic [1:0]  exp_strb;
        e      = m_err(w, int'(f3), a);
        n      = m_n(int'(f3));
        exp_rd = (e || w) ? 32'h0 : m_load(int'(f3), a);
        got    = -1;
        check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid) begin
                got = c;
                check({tag, ".rdata"}, resp_rdata, exp_rd);
                check({tag, ".err"}, {31'b0, resp_err}, {31'b0, e});
                check({tag, ".ready_done"}, {31'b0, req_ready}, 32'd0);
                break;
            end
            exp_strb = (!e && c < n) ? (w ? 2'b01 : 2'b10) : 2'b00;
            check({tag, ".strobes"}, {30'b0, mem_MemRead, mem_MemWrite}, {30'b0, exp_strb});
            if (exp_strb != 2'b00)
                check({tag, ".addr"}, mem_address, a + 32'(c));
            if (exp_strb == 2'b01)
                check({tag, ".wbyte"}, mem_write_data, {24'b0, wd[8*c +: 8]});
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(got), e ? 32'd0 : 32'(n));
        if (w && !e)
            for (int i = 0; i < n; i++) refmem[int'(a) + i] = wd[8*i +: 8];
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra, rwd;
        logic [2:0]  rf3;
        bit          rw;
        int          idx, nresp;
        bit          accepting;
        logic [31:0] bb_addr [0:2];
        logic [7:0]  bb_data [0:2];

        for (int i = 0; i < MB; i++) refmem[i] = pat(i);
        rst = 1'b1; init_mem = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        #1;
        check("reset.ready", {31'b0, req_ready}, 32'd1);
        check("reset.busy", {31'b0, busy}, 32'd0);
        check("reset.resp", {30'b0, resp_valid, resp_err}, 32'd0);
        check("reset.mem", {30'b0, mem_MemRead, mem_MemWrite}, 32'd0);
        check("reset.maddr", mem_address, 32'd0);
        @(negedge clk); @(negedge clk);
        init_mem = 1'b0; rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 3'd2, 32'h10, 32'hA1B2C3D4, "sw10");
        for (int i = 0; i < 4; i++) check("sw10.mem", {24'b0, dmem[16 + i]}, {24'b0, refmem[16 + i]});
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw10");
        do_req(1'b0, 3'd0, 32'h13, 32'h0, "lb13");
        do_req(1'b0, 3'd4, 32'h13, 32'h0, "lbu13");
        do_req(1'b0, 3'd1, 32'h12, 32'h0, "lh12");
        do_req(1'b0, 3'd5, 32'h12, 32'h0, "lhu12");
        do_req(1'b0, 3'd2, 32'h11, 32'h0, "lw_mis");
        do_req(1'b0, 3'd1, 32'h3FF, 32'h0, "lh3ff");
        do_req(1'b0, 3'd3, 32'h10, 32'h0, "ld_f3");
        do_req(1'b1, 3'd4, 32'h10, 32'h0, "st_f3");
        do_req(1'b0, 3'd4, 32'h3FF, 32'h0, "lbu3ff");
        do_req(1'b0, 3'd2, 32'h3FC, 32'h0, "lw3fc");
        do_req(1'b0, 3'd0, 32'h400, 32'h0, "lb400");
        do_req(1'b0, 3'd4, 32'hFFFFFFFF, 32'h0, "lbu_top");
        do_req(1'b1, 3'd2, 32'hFFFFFFFC, 32'h0, "sw_top");

        // Reset during the first store byte cycle.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1;
        req_addr = 32'h20; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid.inaccess", {31'b0, mem_MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid.mw", {30'b0, mem_MemRead, mem_MemWrite}, 32'd0);
        check("rst_mid.maddr", mem_address, 32'd0);
        check("rst_mid.mdata", mem_write_data, 32'd0);
        check("rst_mid.ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_mid.noresp", {31'b0, resp_valid}, 32'd0);
        end
        check("rst_mid.m20", {24'b0, dmem[32'h20]}, {24'b0, refmem[32'h20]});
        check("rst_mid.m21", {24'b0, dmem[32'h21]}, {24'b0, refmem[32'h21]});

        // Three SB requests with req_valid held high throughout.
        bb_addr[0] = 32'h30; bb_addr[1] = 32'h31; bb_addr[2] = 32'h40;
        bb_data[0] = 8'h11;  bb_data[1] = 8'h22;  bb_data[2] = 8'h33;
        idx = 0; nresp = 0;
        for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
            if (resp_valid) begin
                check("b2b.err", {31'b0, resp_err}, 32'd0);
                check("b2b.ready_in_done", {31'b0, req_ready}, 32'd0);
                nresp++;
            end
            if (mem_MemWrite) begin
                check("b2b.addr", mem_address, bb_addr[idx - 1]);
                check("b2b.data", mem_write_data, {24'b0, bb_data[idx - 1]});
            end
            accepting = 1'b0;
            if (req_ready && idx < 3) begin
                req_write = 1'b1; req_funct3 = 3'd0;
                req_addr = bb_addr[idx]; req_wdata = {24'hDEAD00 >> 0, bb_data[idx]};
                accepting = 1'b1;
            end
            req_valid = (idx < 3);
            @(posedge clk);
            if (accepting) idx++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b.nresp", 32'(nresp), 32'd3);
        for (int i = 0; i < 3; i++) begin
            refmem[int'(bb_addr[i])] = bb_data[i];
            check("b2b.mem", {24'b0, dmem[int'(bb_addr[i])]}, {24'b0, bb_data[i]});
        end
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            rw  = 1'($urandom);
            rf3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!rw && $urandom_range(0, 1) == 1 && rf3 != 3'd2) rf3 = rf3 | 3'd4;
            case ($urandom_range(0, 5))
                0:       ra = 32'(MB - 4) + 32'($urandom_range(0, 7));
                1:       ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                default: ra = 32'($urandom_range(0, 63));
            endcase
            rwd = $urandom;
            do_req(rw, rf3, ra, rwd, "rand");
        end
        for (int i = 0; i < 72; i++) check("final.mem", {24'b0, dmem[i]}, {24'b0, refmem[i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
